vga_wb_master: RTL and testbench
================================

# vga_wb_master

Wishbone master that fetches pixel data from video memory into the line FIFO of the VGA/LCD controller. It reads consecutive 32-bit words starting at the active video base address (VBARa or VBARb) in bursts sized by the control register's burst-length field. At end of frame it optionally switches memory banks and reports the switch and any bus error to the register block as one-cycle interrupt requests.

## Interface
Parameters:
- FWIDTH, 24: width of the frame word counter.

Ports:
- CLK_I  in  1  system clock; all logic on rising edge.
- nRESET  in  1  asynchronous active-low reset.
- ADR_O  out  30  word address [31:2].
- DAT_I  in  32  read data.
- SEL_O  out  4  constant 4'b1111.
- WE_O  out  1  constant 0.
- CYC_O  out  1  bus cycle; held for a whole burst.
- STB_O  out  1  strobe.
- ACK_I  in  1  transfer acknowledge.
- ERR_I  in  1  bus error.
- ven  in  1  video enable.
- vbl  in  2  burst length: 00=1, 01=2, 10=4, 11=8 words.
- vbsw  in  1  bank switch enable, sampled at end of frame.
- VBARa  in  30  bank A base, word address.
- VBARb  in  30  bank B base, word address.
- fwords  in  FWIDTH  words per frame; 0 is illegal.
- fifo_free  in  4  free FIFO entries, saturating at 15.
- fifo_wreq  out  1  FIFO write strobe.
- fifo_d  out  32  FIFO write data.
- avmp  out  1  active video memory page: 0 = A, 1 = B.
- vbsint_out  out  1  bank-switch interrupt pulse.
- sint_out  out  1  system-error interrupt pulse.

## Operation
- States: IDLE, BURST, GAP, HALT.
- IDLE:
  - ven=0 forces ptr to the active bank base (VBARa if avmp=0, else VBARb) and cnt to 0. avmp is kept.
  - ven=1 and fifo_free >= blen moves to BURST.
  - blen = min(vbl length, fwords-cnt). It is latched in rem on entry and held for the rest of the burst.
- BURST: CYC_O=STB_O=1, ADR_O=ptr. On each ACK_I (with ERR_I=0):
  - fifo_d<=DAT_I, fifo_wreq<=1.
  - ptr+1, cnt+1, rem-1.
  - When rem reaches 0, go to GAP.
- End of frame is cnt+1==fwords on an ACK:
  - cnt<=0.
  - If vbsw=1: avmp toggles, vbsint_out pulses, and ptr loads the other bank's base.
  - If vbsw=0: ptr reloads the current bank's base.
- GAP: one cycle with CYC_O=STB_O=0, then IDLE.
- ERR_I in BURST:
  - Terminate the cycle with no FIFO write and pulse sint_out. ERR_I wins over a simultaneous ACK_I.
  - Go to HALT, with CYC_O=0.
  - Leave HALT for IDLE only when ven=0.
- ven deasserted mid-burst: the burst completes, then GAP, then IDLE. The IDLE ven=0 rule then resets ptr and cnt.
- Address arithmetic wraps modulo 2^30. The counter compare is unsigned.
- Reset values: CYC_O=0, STB_O=0, ADR_O=0, fifo_wreq=0, fifo_d=0, avmp=0, vbsint_out=0, sint_out=0, state IDLE, ptr=0, cnt=0.

## Timing
- The IDLE-to-BURST decision is registered: CYC_O/STB_O rise one cycle after the condition holds.
- ADR_O advances on the clock edge that samples ACK_I, and STB_O stays high. Zero-wait-state slaves therefore sustain 1 word per cycle.
- fifo_wreq/fifo_d appear one cycle after the ACK_I edge, for exactly one cycle per word.
- vbsint_out, avmp toggle and sint_out are registered, asserted the cycle after the qualifying ACK_I/ERR_I edge, and last one cycle.
- Minimum spacing between bursts is 1 idle cycle (GAP) plus the 1-cycle IDLE decision.
- VBARa/VBARb/vbl/fwords may change at any time. They take effect only where sampled: burst start, end of frame, and IDLE with ven=0.

## Configuration
- VGA_WB_MASTER_BURST_EN:
  - Defined: bursts of 1/2/4/8 words per vbl, with CYC_O held across the burst.
  - Undefined: vbl is ignored and blen is forced to 1. Every word is its own cycle followed by GAP, and the fifo_free threshold is 1.

## Test plan
- Burst fetch:
  - Stimulus: VBARa=0x100, vbl=10, fwords=8, fifo_free=15, zero-wait slave, ven=1.
  - Response: two 4-word bursts with ADR_O 0x100–0x103 and 0x104–0x107, CYC_O low for GAP between them, and 8 fifo_wreq pulses with matching data.
- Bank switch:
  - Stimulus: vbsw=1, VBARb=0x200, fwords=8.
  - Response: after the 8th ACK, avmp=1 and vbsint_out pulses once; the next burst starts at ADR_O=0x200. With vbsw=0 the next burst restarts at 0x100 and avmp stays 0.
- Truncation:
  - Stimulus: fwords=6, vbl=11.
  - Response: first burst 6 words, then frame wrap; no access at base+6.
- FIFO back-pressure:
  - Stimulus: fifo_free=3, vbl=10.
  - Response: no CYC_O until fifo_free>=4, then a 4-word burst.
- Bus error:
  - Stimulus: ERR_I together with ACK_I on the 2nd word.
  - Response: no FIFO write for that word, sint_out pulses once, CYC_O drops and stays low while ven=1. Resumes after ven 0→1 from the active base.
- Reset and disable:
  - Stimulus: nRESET asserted mid-burst.
  - Response: all outputs at reset values immediately.
  - Stimulus: ven dropped mid-burst.
  - Response: the remaining ACKs are accepted, then CYC_O goes low and stays low.
  - Build without the macro: every word appears as a separate 1-word cycle.

Source files
------------

// File: rtl/vga_wb_master_if.sv
// vga_wb_master_if: Wishbone read-master bus bundle for the VGA pixel fetcher
interface vga_wb_master_if;
    logic [29:0] ADR_O;
    logic [31:0] DAT_I;
    logic [3:0] SEL_O;
    logic WE_O, CYC_O, STB_O, ACK_I, ERR_I;
    modport master (output ADR_O, SEL_O, WE_O, CYC_O, STB_O, input DAT_I, ACK_I, ERR_I);
    modport slave (input ADR_O, SEL_O, WE_O, CYC_O, STB_O, output DAT_I, ACK_I, ERR_I);
endinterface

// File: rtl/vga_wb_master.sv
// vga_wb_master: fetches video memory words over Wishbone into the VGA line FIFO
// Define VGA_WB_MASTER_BURST_EN for vbl-sized bursts; without it every fetch is a single word.
module vga_wb_master #(parameter int FWIDTH = 24) (
    input logic CLK_I,
    input logic nRESET,
    vga_wb_master_if.master wb,
    input logic ven,
    input logic [1:0] vbl,
    input logic vbsw,
    input logic [29:0] VBARa,
    input logic [29:0] VBARb,
    input logic [FWIDTH-1:0] fwords,
    input logic [3:0] fifo_free,
    output logic fifo_wreq,
    output logic [31:0] fifo_d,
    output logic avmp,
    output logic vbsint_out,
    output logic sint_out
);
    typedef enum logic [1:0] {IDLE, BURST, GAP, HALT} state_t;
    state_t state;
    logic [29:0] ptr;
    logic [FWIDTH-1:0] cnt, left;
    logic [3:0] rem, vlen, blen;
    logic cyc, eof;
`ifdef VGA_WB_MASTER_BURST_EN
    assign vlen = 4'd1 << vbl;
`else
    assign vlen = 4'd1;
`endif
    // a burst never crosses the end of the frame
    assign left = fwords - cnt;
    assign blen = (left != '0 && left < FWIDTH'(vlen)) ? left[3:0] : vlen;
    assign eof = (cnt + FWIDTH'(1)) == fwords;
    assign wb.ADR_O = ptr;
    assign wb.SEL_O = 4'hf;
    assign wb.WE_O = 1'b0;
    assign wb.CYC_O = cyc;
    assign wb.STB_O = cyc;
    always_ff @(posedge CLK_I or negedge nRESET)
        if (!nRESET) begin
            state <= IDLE;
            ptr <= '0;
            cnt <= '0;
            rem <= '0;
            cyc <= 1'b0;
            fifo_wreq <= 1'b0;
            fifo_d <= '0;
            avmp <= 1'b0;
            vbsint_out <= 1'b0;
            sint_out <= 1'b0;
        end else begin
            fifo_wreq <= 1'b0;
            vbsint_out <= 1'b0;
            sint_out <= 1'b0;
            case (state)
                IDLE:
                    if (!ven) begin
                        ptr <= avmp ? VBARb : VBARa;
                        cnt <= '0;
                    end else if (fifo_free >= blen) begin
                        state <= BURST;
                        cyc <= 1'b1;
                        rem <= blen;
                    end
                BURST:
                    if (wb.ERR_I) begin
                        state <= HALT;
                        cyc <= 1'b0;
                        sint_out <= 1'b1;
                    end else if (wb.ACK_I) begin
                        fifo_wreq <= 1'b1;
                        fifo_d <= wb.DAT_I;
                        rem <= rem - 4'd1;
                        if (rem == 4'd1) begin
                            state <= GAP;
                            cyc <= 1'b0;
                        end
                        if (eof) begin
                            cnt <= '0;
                            avmp <= avmp ^ vbsw;
                            vbsint_out <= vbsw;
                            ptr <= (avmp ^ vbsw) ? VBARb : VBARa;
                        end else begin
                            cnt <= cnt + FWIDTH'(1);
                            ptr <= ptr + 30'd1;
                        end
                    end
                GAP: state <= IDLE;
                HALT: state <= ven ? HALT : IDLE;
            endcase
        end
endmodule

// File: tb/tb_vga_wb_master.sv
// tb_vga_wb_master: directed checks of the VGA Wishbone pixel fetcher
module tb_vga_wb_master;
`ifdef VGA_WB_MASTER_BURST_EN
    localparam int BL = 4;
    localparam int TL = 6;
`else
    localparam int BL = 1;
    localparam int TL = 1;
`endif
    logic CLK_I = 0, nRESET = 0, ven = 0, vbsw = 0, err_arm = 0, clr = 0;
    logic [1:0] vbl = 2'd2;
    logic [29:0] VBARa = 30'h100, VBARb = 30'h200;
    logic [23:0] fwords = 24'd8;
    logic [3:0] fifo_free = 4'd15;
    logic fifo_wreq, avmp, vbsint_out, sint_out;
    logic [31:0] fifo_d;
    int n_cmp = 0, n_bad = 0;
    vga_wb_master_if wb();
    // zero-wait slave returning a per-address data pattern, optional error at word 0x101
    assign wb.ACK_I = wb.CYC_O & wb.STB_O;
    assign wb.ERR_I = err_arm & wb.CYC_O & wb.STB_O & (wb.ADR_O == 30'h101);
    assign wb.DAT_I = {wb.ADR_O, 2'b11};
    vga_wb_master #(.FWIDTH(24)) dut (
        .CLK_I(CLK_I), .nRESET(nRESET), .wb(wb), .ven(ven), .vbl(vbl), .vbsw(vbsw),
        .VBARa(VBARa), .VBARb(VBARb), .fwords(fwords), .fifo_free(fifo_free),
        .fifo_wreq(fifo_wreq), .fifo_d(fifo_d), .avmp(avmp),
        .vbsint_out(vbsint_out), .sint_out(sint_out));
    always #5 CLK_I = ~CLK_I;
    logic [29:0] acc_q[$];
    logic [31:0] fq[$];
    int bl_q[$], gap_q[$];
    int cur_bl = 0, gap_run = 0, vbs_cnt = 0, sint_cnt = 0;
    logic cyc_d = 0, seen = 0, hit;
    always @(negedge CLK_I) begin
        if (clr) begin
            acc_q.delete(); fq.delete(); bl_q.delete(); gap_q.delete();
            cur_bl = 0; gap_run = 0; vbs_cnt = 0; sint_cnt = 0; seen = 0;
        end
        hit = wb.CYC_O & wb.STB_O & wb.ACK_I & !wb.ERR_I;
        if (hit) acc_q.push_back(wb.ADR_O);
        if (fifo_wreq) fq.push_back(fifo_d);
        vbs_cnt += int'(vbsint_out);
        sint_cnt += int'(sint_out);
        if (wb.CYC_O) begin
            if (!cyc_d && seen) gap_q.push_back(gap_run);
            cur_bl += int'(hit);
        end else begin
            if (cyc_d) begin
                bl_q.push_back(cur_bl);
                cur_bl = 0;
                gap_run = 0;
                seen = 1;
            end
            gap_run++;
        end
        cyc_d = wb.CYC_O;
    end
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step(int n = 1);
        repeat (n) begin
            @(negedge CLK_I);
            #1;
        end
    endtask
    task automatic clear_logs();
        clr = 1;
        step();
        clr = 0;
    endtask
    task automatic wait_acks(int n);
        int t = 0;
        while (acc_q.size() < n && t < 2000) begin
            step();
            t++;
        end
        if (acc_q.size() < n) chk("ack_timeout", acc_q.size(), n);
    endtask
    task automatic do_reset();
        nRESET = 0;
        ven = 0;
        step(2);
        nRESET = 1;
        step(3);
        clear_logs();
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        step(2);
        chk("rst_cyc", wb.CYC_O, 0);
        chk("rst_stb", wb.STB_O, 0);
        chk("rst_adr", wb.ADR_O, 0);
        chk("rst_wreq", fifo_wreq, 0);
        chk("rst_avmp", avmp, 0);
        chk("rst_sint", sint_out, 0);
        nRESET = 1;
        step(3);
        clear_logs();
        ven = 1;
        wait_acks(10);
        for (int i = 0; i < 10; i++) chk("t1_adr", acc_q[i], 32'(30'h100 + i % 8));
        for (int i = 0; i < 8; i++) chk("t1_data", fq[i], {30'h100 + 30'(i), 2'b11});
        chk("t1_bl0", bl_q[0], BL);
        chk("t1_bl1", bl_q[1], BL);
        chk("t1_gap", gap_q[0], 2);
        chk("t1_avmp", avmp, 0);
        chk("t1_vbs", vbs_cnt, 0);
        ven = 0;
        step(20);
        chk("t1_idle_cyc", wb.CYC_O, 0);
        vbsw = 1;
        clear_logs();
        ven = 1;
        wait_acks(10);
        ven = 0;
        step(20);
        chk("t2_adr7", acc_q[7], 32'h107);
        chk("t2_adr8", acc_q[8], 32'h200);
        chk("t2_adr9", acc_q[9], 32'h201);
        chk("t2_avmp", avmp, 1);
        chk("t2_vbs", vbs_cnt, 1);
        vbsw = 0;
        fwords = 24'd6;
        vbl = 2'd3;
        do_reset();
        ven = 1;
        wait_acks(8);
        ven = 0;
        step(20);
        chk("t3_adr5", acc_q[5], 32'h105);
        chk("t3_adr6", acc_q[6], 32'h100);
        chk("t3_adr7", acc_q[7], 32'h101);
        chk("t3_bl0", bl_q[0], TL);
        fwords = 24'd8;
        vbl = 2'd2;
        do_reset();
        fifo_free = 4'(BL - 1);
        ven = 1;
        step(20);
        chk("t4_noacc", acc_q.size(), 0);
        chk("t4_nocyc", wb.CYC_O, 0);
        fifo_free = 4'd15;
        wait_acks(4);
        step(3);
        chk("t4_bl0", bl_q[0], BL);
        chk("t4_adr0", acc_q[0], 32'h100);
        chk("t4_adr3", acc_q[3], 32'h103);
        ven = 0;
        step(20);
        do_reset();
        err_arm = 1;
        ven = 1;
        step(30);
        chk("t5_acks", acc_q.size(), 1);
        chk("t5_writes", fq.size(), 1);
        chk("t5_sint", sint_cnt, 1);
        chk("t5_halt_cyc", wb.CYC_O, 0);
        err_arm = 0;
        ven = 0;
        step(2);
        clear_logs();
        ven = 1;
        wait_acks(2);
        chk("t5_resume0", acc_q[0], 32'h100);
        chk("t5_resume1", acc_q[1], 32'h101);
        ven = 0;
        step(20);
        do_reset();
        ven = 1;
        wait_acks(1);
        ven = 0;
        step(20);
        chk("t6_acks", acc_q.size(), BL);
        chk("t6_cyc", wb.CYC_O, 0);
        do_reset();
        ven = 1;
        wait_acks(2);
        nRESET = 0;
        #1;
        chk("t7_cyc", wb.CYC_O, 0);
        chk("t7_stb", wb.STB_O, 0);
        chk("t7_adr", wb.ADR_O, 0);
        chk("t7_wreq", fifo_wreq, 0);
        chk("t7_fifo_d", fifo_d, 0);
        chk("t7_avmp", avmp, 0);
        chk("t7_vbs", vbsint_out, 0);
        chk("t7_sint", sint_out, 0);
        step(2);
        nRESET = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
